// File: rtl/sysu_rom_scanner_pkg.sv
// Shared types and widths for the ROM scanner block and its address counter.
package sysu_rom_scanner_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/sysu_rom_addr_cnt.sv
// ROM address register: clear-to-zero has priority over increment; the
// increment wraps naturally at the top of the 3-bit range.
module sysu_rom_addr_cnt
  import sysu_rom_scanner_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      addr <= '0;
    else if (clr) addr <= '0;
    else if (inc) addr <= addr + ADDR_W'(1);
  end

endmodule

// File: rtl/sysu_rom_scanner.sv
// Walks an external 8x8 combinational ROM from address 0 to LAST_ADDR and
// hands each word downstream over a VALID/READY handshake.
// Optional macro SYSU_ROM_SCANNER_LOOP_EN adds a LOOP input for continuous scanning.
//
// state | meaning
// IDLE  | waiting for START, address parked at 0
// FETCH | ROM output for current address is captured into Q
// HOLD  | Q presented with VALID, waiting for READY
// FIN   | DONE pulse, address returns to 0
module sysu_rom_scanner
  import sysu_rom_scanner_pkg::*;
#(
  parameter logic [ADDR_W-1:0] LAST_ADDR = 3'b111
) (
`ifdef SYSU_ROM_SCANNER_LOOP_EN
  input  logic              LOOP,
`endif
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              STOP,
  input  logic              READY,
  input  logic [DATA_W-1:0] Rin,
  output logic              A2,
  output logic              A1,
  output logic              A0,
  output logic [DATA_W-1:0] Q,
  output logic              VALID,
  output logic              BUSY,
  output logic              DONE
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic              addr_clr, addr_inc;
  logic              q_load, valid_set, valid_clr;
  logic              last_word;

  sysu_rom_addr_cnt u_addr_cnt (
    .clk  (CLK),
    .rst  (RST),
    .clr  (addr_clr),
    .inc  (addr_inc),
    .addr (addr)
  );

  assign last_word = (addr == LAST_ADDR);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    addr_clr  = 1'b0;
    addr_inc  = 1'b0;
    q_load    = 1'b0;
    valid_set = 1'b0;
    valid_clr = 1'b0;
    // STOP wins over everything once a scan is running, including a handshake
    if (STOP && (state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
      addr_clr  = 1'b1;
      valid_clr = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START && !STOP) begin
            state_nxt = ST_FETCH;
            addr_clr  = 1'b1;
          end
        end
        ST_FETCH: begin
          q_load    = 1'b1;
          valid_set = 1'b1;
          state_nxt = ST_HOLD;
        end
        ST_HOLD: begin
          if (VALID && READY) begin
            valid_clr = 1'b1;
            if (!last_word) begin
              addr_inc  = 1'b1;
              state_nxt = ST_FETCH;
            end else begin
`ifdef SYSU_ROM_SCANNER_LOOP_EN
              if (LOOP) begin
                addr_clr  = 1'b1;
                state_nxt = ST_FETCH;
              end else begin
                state_nxt = ST_FIN;
              end
`else
              state_nxt = ST_FIN;
`endif
            end
          end
        end
        ST_FIN: begin
          addr_clr  = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: begin
          addr_clr  = 1'b1;
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Q only changes on a fetch, so the last word stays visible after a scan ends
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Q     <= '0;
      VALID <= 1'b0;
    end else begin
      if (q_load) Q <= Rin;
      if (valid_clr)      VALID <= 1'b0;
      else if (valid_set) VALID <= 1'b1;
    end
  end

  assign {A2, A1, A0} = addr;
  assign BUSY = (state != ST_IDLE);
  assign DONE = (state == ST_FIN);

endmodule

// File: tb/tb_sysu_rom_scanner.sv
// Directed bench: three scanners (LAST_ADDR 7, 2, 0) on one clock, each with
// its own behavioural ROM loaded 11,22,...,88.
module tb_sysu_rom_scanner;

  logic       CLK = 1'b0;
  logic       RST;
  logic       STOP;
  logic       READY;
  logic       loop_en;
  logic [2:0] start;

  logic [7:0] q_v     [3];
  logic [7:0] rin_v   [3];
  logic [2:0] a_v     [3];
  logic       valid_v [3];
  logic       busy_v  [3];
  logic       done_v  [3];

  localparam logic [7:0] EXP [8] = '{8'h11, 8'h22, 8'h33, 8'h44,
                                     8'h55, 8'h66, 8'h77, 8'h88};

  int total  = 0;
  int passed = 0;

  always #5 CLK = ~CLK;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    localparam logic [2:0] LA = (i == 0) ? 3'd7 : (i == 1) ? 3'd2 : 3'd0;
    assign rin_v[i] = EXP[a_v[i]];
    sysu_rom_scanner #(.LAST_ADDR(LA)) dut (
`ifdef SYSU_ROM_SCANNER_LOOP_EN
      .LOOP  ((i == 0) ? loop_en : 1'b0),
`endif
      .CLK   (CLK),
      .RST   (RST),
      .START (start[i]),
      .STOP  (STOP),
      .READY (READY),
      .Rin   (rin_v[i]),
      .A2    (a_v[i][2]),
      .A1    (a_v[i][1]),
      .A0    (a_v[i][0]),
      .Q     (q_v[i]),
      .VALID (valid_v[i]),
      .BUSY  (busy_v[i]),
      .DONE  (done_v[i])
    );
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // two edges per word: FETCH (VALID low, address k-1) then HOLD (Q=word k)
  task automatic run_word(input int d, input int k);
    step();
    start = 3'b000;
    chk($sformatf("d%0d_w%0d_fetch_valid", d, k), valid_v[d], 0);
    chk($sformatf("d%0d_w%0d_fetch_addr", d, k), a_v[d], k - 1);
    chk($sformatf("d%0d_w%0d_fetch_done", d, k), done_v[d], 0);
    step();
    chk($sformatf("d%0d_w%0d_q", d, k), q_v[d], EXP[k-1]);
    chk($sformatf("d%0d_w%0d_valid", d, k), valid_v[d], 1);
    chk($sformatf("d%0d_w%0d_addr", d, k), a_v[d], k - 1);
    chk($sformatf("d%0d_w%0d_busy", d, k), busy_v[d], 1);
  endtask

  task automatic finish_scan(input int d, input logic [7:0] last_q);
    step();
    chk($sformatf("d%0d_fin_done", d), done_v[d], 1);
    chk($sformatf("d%0d_fin_valid", d), valid_v[d], 0);
    step();
    chk($sformatf("d%0d_idle_done", d), done_v[d], 0);
    chk($sformatf("d%0d_idle_busy", d), busy_v[d], 0);
    chk($sformatf("d%0d_idle_addr", d), a_v[d], 0);
    chk($sformatf("d%0d_idle_q", d), q_v[d], last_q);
  endtask

  initial begin
    RST = 1'b1; STOP = 1'b0; READY = 1'b1; loop_en = 1'b0; start = 3'b000;
    step();
    step();
    chk("rst_q", q_v[0], 0);
    chk("rst_addr", a_v[0], 0);
    chk("rst_valid", valid_v[0], 0);
    chk("rst_busy", busy_v[0], 0);
    chk("rst_done", done_v[0], 0);
    RST = 1'b0;
    step();

    // full scan, READY high: DONE after edge 17
    start[0] = 1'b1;
    for (int k = 1; k <= 8; k++) run_word(0, k);
    finish_scan(0, 8'h88);

    // START with STOP in IDLE: STOP wins
    start[0] = 1'b1; STOP = 1'b1;
    step();
    chk("idle_stop_busy", busy_v[0], 0);
    start[0] = 1'b0; STOP = 1'b0;

    // READY low for 5 cycles at word 3, with a stray START held meanwhile
    start[0] = 1'b1;
    for (int k = 1; k <= 3; k++) run_word(0, k);
    READY = 1'b0; start[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("stall_q", q_v[0], 8'h33);
      chk("stall_addr", a_v[0], 3'b010);
      chk("stall_valid", valid_v[0], 1);
    end
    READY = 1'b1; start[0] = 1'b0;
    for (int k = 4; k <= 8; k++) run_word(0, k);
    finish_scan(0, 8'h88);

    // STOP coinciding with handshake of word 4
    start[0] = 1'b1;
    for (int k = 1; k <= 4; k++) run_word(0, k);
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    chk("stop_busy", busy_v[0], 0);
    chk("stop_valid", valid_v[0], 0);
    chk("stop_addr", a_v[0], 0);
    chk("stop_q", q_v[0], 8'h44);
    chk("stop_done", done_v[0], 0);
    step();
    chk("stop_done2", done_v[0], 0);
    chk("stop_busy2", busy_v[0], 0);

    // async reset at word 6
    start[0] = 1'b1;
    for (int k = 1; k <= 6; k++) run_word(0, k);
    RST = 1'b1;
    #1;
    chk("arst_q", q_v[0], 0);
    chk("arst_addr", a_v[0], 0);
    chk("arst_valid", valid_v[0], 0);
    chk("arst_busy", busy_v[0], 0);
    #1;
    RST = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("arst_no_done", done_v[0], 0);
      chk("arst_idle", busy_v[0], 0);
    end
    start[0] = 1'b1;
    run_word(0, 1);
    for (int k = 2; k <= 8; k++) run_word(0, k);
    finish_scan(0, 8'h88);

    // short scans: LAST_ADDR=2 and LAST_ADDR=0 (DONE after edge 3)
    start[1] = 1'b1;
    for (int k = 1; k <= 3; k++) run_word(1, k);
    finish_scan(1, 8'h33);
    start[2] = 1'b1;
    run_word(2, 1);
    finish_scan(2, 8'h11);

`ifdef SYSU_ROM_SCANNER_LOOP_EN
    loop_en = 1'b1;
    start[0] = 1'b1;
    for (int k = 1; k <= 8; k++) run_word(0, k);
    loop_en = 1'b0;
    for (int k = 1; k <= 8; k++) run_word(0, k);
    finish_scan(0, 8'h88);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sysu_rom_scanner.md
SYSU_ROM_SCANNER -- requirements
Module: sysu_rom_scanner

Interface
REQ-001 SHALL provide parameter: LAST_ADDR, 3'b111, final ROM address of a scan (0..7).
REQ-002 SHALL provide port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port: START  input  1  scan request, sampled only in IDLE.
REQ-005 SHALL provide port: STOP  input  1  synchronous abort of a running scan.
REQ-006 SHALL provide port: READY  input  1  downstream accepts Q when high with VALID.
REQ-007 SHALL provide port: Rin  input  8  data returned by the 8x8 ROM (its Dout).
REQ-008 SHALL provide ports: A2, A1, A0  output  1 each  registered ROM address, MSB..LSB.
REQ-009 SHALL provide port: Q  output  8  registered ROM word presented downstream.
REQ-010 SHALL provide port: VALID  output  1  Q holds an unaccepted word.
REQ-011 SHALL provide port: BUSY  output  1  high in every state except IDLE.
REQ-012 SHALL provide port: DONE  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-013 SHALL implement states IDLE, FETCH, HOLD and FIN.
REQ-014 IDLE: START=1 SHALL load address 0 and go to FETCH; START=0 SHALL remain in IDLE.
REQ-015 FETCH: SHALL capture Rin into Q, set VALID=1 and go to HOLD (one-cycle ROM latency, combinational ROM).
REQ-016 HOLD with VALID&READY and address != LAST_ADDR: SHALL clear VALID, increment address and go to FETCH.
REQ-017 HOLD with VALID&READY and address == LAST_ADDR: SHALL clear VALID and go to FIN.
REQ-018 HOLD with READY=0: SHALL hold Q, VALID and address unchanged for any number of cycles.
REQ-019 FIN: SHALL assert DONE for exactly that cycle, reset address to 0 and return to IDLE.
REQ-020 Throughput SHALL be one word per two cycles with READY held high; a scan of N=LAST_ADDR+1 words SHALL take 2N+1 cycles from START to DONE.
REQ-021 START outside IDLE SHALL be ignored.
REQ-022 STOP in FETCH, HOLD or FIN SHALL force IDLE, VALID=0, DONE=0 and address=0 at the next edge; STOP SHALL take priority over a simultaneous handshake; STOP in IDLE SHALL have no effect and SHALL override a simultaneous START.
REQ-023 Q SHALL retain its last value after handshake, STOP and FIN; only FETCH or reset SHALL change it.
REQ-024 LAST_ADDR=0 SHALL produce a single-word scan.

Reset
REQ-025 RST=1 SHALL immediately force state IDLE, A2..A0=0, Q=8'h00, VALID=0, BUSY=0, DONE=0, independent of CLK.
REQ-026 Reset asserted mid-scan SHALL discard the scan; no DONE SHALL follow deassertion.

Configuration
REQ-027 Macro SYSU_ROM_SCANNER_LOOP_EN defined: SHALL add input port LOOP (1 bit); a last-word handshake with LOOP=1 SHALL wrap address to 0 and go to FETCH with no DONE pulse; LOOP=0 SHALL behave as REQ-017.
REQ-028 Macro undefined: port LOOP SHALL not exist and every scan SHALL end per REQ-017.

Structure
REQ-029 Package sysu_rom_scanner_pkg SHALL hold the state enumeration, ADDR_W=3 and DATA_W=8.
REQ-030 The 3-bit address register with load-zero, increment and wrap SHALL be sub-module sysu_rom_addr_cnt; the ROM itself SHALL be instantiated outside this block.

Verification (ROM loaded R1..R8 = 8'h11,8'h22,...,8'h88)
REQ-031 START pulse, READY=1 -> Q=11,22,...,88 with one VALID cycle each, A stepping 0..7, DONE at cycle 17, BUSY low after.
REQ-032 READY=0 for 5 cycles at word 3 -> Q=33 and A=3'b010 held, VALID high throughout, then sequence resumes at 44.
REQ-033 STOP together with handshake of word 4 -> next cycle IDLE, VALID=0, A=0, Q=44, no DONE.
REQ-034 RST pulse asynchronously mid-scan at word 6 -> outputs zero before next CLK edge; later START restarts at 11.
REQ-035 LAST_ADDR=3'b010 -> words 11,22,33 then DONE; LAST_ADDR=0 -> word 11 then DONE at cycle 3.
REQ-036 With SYSU_ROM_SCANNER_LOOP_EN, LOOP=1 -> 88 followed directly by 11 with no DONE; dropping LOOP before word 8 -> DONE after 88.
